// File: rtl/psum_out_fifo_pkg.sv
// Shared constants and helpers for the partial-sum realignment FIFO.
package psum_out_pkg;

  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int DEPTH   = 64;

  // Pointer carries one extra wrap bit above the storage index.
  function automatic int ptr_w(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/psum_out_fifo_col_fifo.sv
// Single-column FIFO: storage, wrap-bit pointers, full/empty and write-drop indication.
module psum_col_fifo
  import psum_out_pkg::*;
#(
  parameter int DATA_W  = PSUM_BW,
  parameter int ENTRIES = DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              drop_o
);

  localparam int PW = ptr_w(ENTRIES);
  localparam int AW = PW - 1;

  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [DATA_W-1:0] mem_q [ENTRIES];
  logic              full, empty, wr_ok, rd_ok;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  // Full is judged on pre-pop pointers, so a write racing a pop on a full FIFO is dropped.
  assign wr_ok = wr_i && !full;
  assign rd_ok = rd_i && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_ok) wptr_d = wptr_q + PW'(1);
    if (rd_ok) rptr_d = rptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !reset) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q[AW-1:0]];
  assign empty_o = empty;
  assign full_o  = full;
  assign drop_o  = wr_i && full;

endmodule

// File: rtl/psum_out_fifo.sv
// Realigns diagonally drained MAC-array column sums into whole rows.
// Optional PSUM_OUT_RELU_EN rectifies each popped lane before it is registered.
module psum_out_fifo
  import psum_out_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in_psum,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   out_vld,
  output logic                   o_valid,
  output logic                   o_ready,
  output logic                   o_full,
  output logic                   overflow
);

  logic [psum_bw*col-1:0] head;
  logic [col-1:0]         empty, full, drop;
  logic                   rd_acc;

  logic [psum_bw*col-1:0] out_q, out_d;
  logic                   out_vld_q, out_vld_d;
  logic                   overflow_q, overflow_d;

  function automatic logic [psum_bw-1:0] lane_fmt(input logic [psum_bw-1:0] x);
`ifdef PSUM_OUT_RELU_EN
    logic signed [psum_bw-1:0] s;
    s = $signed(x);
    return (s < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  for (genvar c = 0; c < col; c++) begin : g_col
    psum_col_fifo #(
      .DATA_W  (psum_bw),
      .ENTRIES (depth)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_i    (wr[c]),
      .din_i   (in_psum[c*psum_bw +: psum_bw]),
      .rd_i    (rd_acc),
      .dout_o  (head[c*psum_bw +: psum_bw]),
      .empty_o (empty[c]),
      .full_o  (full[c]),
      .drop_o  (drop[c])
    );
  end

  assign o_valid = &(~empty);
  assign o_full  = |full;
  assign o_ready = !o_full;
  assign rd_acc  = rd && o_valid;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = rd_acc;
    overflow_d = overflow_q | (|drop);
    if (rd_acc) begin
      for (int c = 0; c < col; c++) begin
        out_d[c*psum_bw +: psum_bw] = lane_fmt(head[c*psum_bw +: psum_bw]);
      end
    end
  end

  // Output stage: popped row, its valid pulse and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      overflow_q <= overflow_d;
    end
  end

  assign out      = out_q;
  assign out_vld  = out_vld_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_psum_out_fifo.sv
// Directed bench for psum_out_fifo with 8 columns of 16 bits and 4-entry column FIFOs.
module tb_psum_out_fifo;

  localparam int NC = 8;
  localparam int BW = 16;
  localparam int W  = NC * BW;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  in_psum;
  logic [NC-1:0] wr;
  logic          rd;
  logic [W-1:0]  out;
  logic          out_vld, o_valid, o_ready, o_full, overflow;

  int checks = 0;
  int errors = 0;

  psum_out_fifo #(.col(NC), .psum_bw(BW), .depth(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_psum  (in_psum),
    .wr       (wr),
    .rd       (rd),
    .out      (out),
    .out_vld  (out_vld),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_full   (o_full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] row(input int r);
    logic [W-1:0] v;
    for (int c = 0; c < NC; c++) v[c*BW +: BW] = 16'(r * 256 + c + 16);
    return v;
  endfunction

  logic [W-1:0] exp_row;

  initial begin
    reset = 1'b1; wr = '0; rd = 1'b0; in_psum = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_out", out, '0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_ready", o_ready, 1);
    chk("rst_o_full", o_full, 0);
    chk("rst_overflow", overflow, 0);

    // Skewed fill: column c writes 100+c at cycle c
    for (int c = 0; c < NC; c++) begin
      in_psum = {NC{16'hDEAD}};
      in_psum[c*BW +: BW] = 16'(100 + c);
      wr = NC'(1 << c);
      if (c == NC - 1) chk("skew_valid_before_last", o_valid, 0);
      step();
    end
    wr = '0;
    chk("skew_valid_after_last", o_valid, 1);
    for (int c = 0; c < NC; c++) exp_row[c*BW +: BW] = 16'(100 + c);
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("skew_out", out, exp_row);
    chk("skew_out_vld", out_vld, 1);
    chk("skew_valid_drained", o_valid, 0);
    step();
    chk("skew_vld_pulse", out_vld, 0);

    // Pop request while empty is ignored
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("empty_rd_out_held", out, exp_row);
    chk("empty_rd_vld", out_vld, 0);

    // Column 0 alone: 4 writes fill it, 5th is dropped
    for (int i = 0; i < 5; i++) begin
      in_psum = '0;
      in_psum[BW-1:0] = 16'(200 + i);
      wr = NC'(1);
      step();
      if (i == 3) begin
        chk("ovf_full_at4", o_full, 1);
        chk("ovf_ready_at4", o_ready, 0);
        chk("ovf_none_at4", overflow, 0);
      end
    end
    wr = '0;
    chk("ovf_set", overflow, 1);
    chk("ovf_others_empty", o_valid, 0);
    step();
    chk("ovf_sticky", overflow, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("ovf_cleared_by_reset", overflow, 0);
    chk("ovf_full_cleared", o_full, 0);

    // All columns full, then write+pop in the same cycle
    for (int r = 0; r < 4; r++) begin
      wr = '1; in_psum = row(r);
      step();
    end
    chk("allfull_o_full", o_full, 1);
    wr = '1; in_psum = row(9); rd = 1'b1;
    step();
    wr = '0; rd = 1'b0;
    chk("wrpop_out", out, row(0));
    chk("wrpop_overflow", overflow, 1);
    chk("wrpop_not_full", o_full, 0);
    chk("wrpop_valid", o_valid, 1);
    for (int r = 1; r < 4; r++) begin
      rd = 1'b1;
      step();
      chk($sformatf("wrpop_drain_%0d", r), out, row(r));
    end
    rd = 1'b0;
    chk("wrpop_occupancy_was_3", o_valid, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Wrap-around: stream 10 rows, popping each on the following cycle
    for (int r = 0; r < 10; r++) begin
      wr = '1; in_psum = row(r); rd = (r > 0);
      step();
      if (r > 0) begin
        chk($sformatf("wrap_row_%0d", r - 1), out, row(r - 1));
        chk($sformatf("wrap_vld_%0d", r - 1), out_vld, 1);
      end
    end
    wr = '0; rd = 1'b1;
    step();
    rd = 1'b0;
    chk("wrap_row_9", out, row(9));
    chk("wrap_empty", o_valid, 0);
    chk("wrap_no_drop", overflow, 0);

    // Reset with 3 rows stored, concurrent write/read ignored
    for (int r = 0; r < 3; r++) begin
      wr = '1; in_psum = row(20 + r);
      step();
    end
    wr = '0;
    chk("rst3_valid_before", o_valid, 1);
    reset = 1'b1; rd = 1'b1; wr = '1; in_psum = row(30);
    step();
    reset = 1'b0; rd = 1'b0; wr = '0;
    chk("rst3_valid", o_valid, 0);
    chk("rst3_out", out, '0);
    chk("rst3_out_vld", out_vld, 0);
    chk("rst3_overflow", overflow, 0);

    // Signed lanes through the output stage
    for (int c = 0; c < NC; c++) in_psum[c*BW +: BW] = 16'(c);
    in_psum[0*BW +: BW] = 16'hFFF0;
    in_psum[1*BW +: BW] = 16'h0005;
    in_psum[7*BW +: BW] = 16'h8000;
    exp_row = in_psum;
`ifdef PSUM_OUT_RELU_EN
    exp_row[0*BW +: BW] = 16'h0000;
    exp_row[7*BW +: BW] = 16'h0000;
`endif
    wr = '1;
    step();
    wr = '0; rd = 1'b1;
    step();
    rd = 1'b0;
    chk("relu_lane0", out[0*BW +: BW], exp_row[0*BW +: BW]);
    chk("relu_lane1", out[1*BW +: BW], 16'h0005);
    chk("relu_row", out, exp_row);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
